// File: rtl/counter_bank.sv
// counter_bank: N_CH independent up/down counters in the sys_clk domain.
// Each channel has a free-running prescaler, clear/load/up/down controls,
// wrap or saturate behaviour at the limits, and a compare-match pulse.
// All per-channel vectors are packed with channel i at [i*W +: W].
//
// Ports:
//   sys_clk, reset  clock; asynchronous active-high reset
//   div_reload      per-channel prescaler reload (tick period = reload+1)
//   ch_enable       prescaler tick auto-increments the channel
//   wrap_mode       1 = wrap at limits, 0 = saturate
//   ch_clear        level clear of count (highest priority)
//   load_pulse      load load_value
//   up_pulse        increment
//   down_pulse      decrement
//   cmp_value       compare value
//   count           registered count
//   tick            prescaler tick, 1 cycle wide
//   eq_zero         registered count == 0
//   cmp_hit         pulse when count becomes equal to cmp_value
//   overflow        pulse when an increment is attempted at all-ones
//   underflow       pulse when a decrement is attempted at zero
module counter_bank #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 24
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [N_CH*DIV_W-1:0]   div_reload,
  input  logic [N_CH-1:0]         ch_enable,
  input  logic [N_CH-1:0]         wrap_mode,
  input  logic [N_CH-1:0]         ch_clear,
  input  logic [N_CH-1:0]         load_pulse,
  input  logic [N_CH*WIDTH-1:0]   load_value,
  input  logic [N_CH-1:0]         up_pulse,
  input  logic [N_CH-1:0]         down_pulse,
  input  logic [N_CH*WIDTH-1:0]   cmp_value,
  output logic [N_CH*WIDTH-1:0]   count,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         eq_zero,
  output logic [N_CH-1:0]         cmp_hit,
  output logic [N_CH-1:0]         overflow,
  output logic [N_CH-1:0]         underflow
);

  logic [N_CH*DIV_W-1:0] div_q;
  logic [N_CH*WIDTH-1:0] count_nxt;
  logic [N_CH-1:0]       ovf_nxt;
  logic [N_CH-1:0]       unf_nxt;
  logic [N_CH-1:0]       match;
  logic [N_CH-1:0]       prev_match;
  logic [WIDTH-1:0]      cur;
  logic                  do_inc;
  logic                  do_dec;

  always_comb begin
    count_nxt = count;
    ovf_nxt   = '0;
    unf_nxt   = '0;
    match     = '0;
    cur       = '0;
    do_inc    = 1'b0;
    do_dec    = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cur      = count[i*WIDTH +: WIDTH];
      match[i] = (cur == cmp_value[i*WIDTH +: WIDTH]);
      do_inc   = 1'b0;
      do_dec   = 1'b0;
      if (ch_clear[i]) begin
        count_nxt[i*WIDTH +: WIDTH] = '0;
      end else if (load_pulse[i]) begin
        count_nxt[i*WIDTH +: WIDTH] = load_value[i*WIDTH +: WIDTH];
      end else if (up_pulse[i] && down_pulse[i]) begin
        // Opposing pulses cancel; a coincident tick is dropped too.
        count_nxt[i*WIDTH +: WIDTH] = cur;
      end else if (up_pulse[i]) begin
        do_inc = 1'b1;
      end else if (down_pulse[i]) begin
        do_dec = 1'b1;
      end else if (tick[i] && ch_enable[i]) begin
        do_inc = 1'b1;
      end

      if (do_inc) begin
        if (cur == '1) begin
          ovf_nxt[i] = 1'b1;
          if (wrap_mode[i]) count_nxt[i*WIDTH +: WIDTH] = '0;
        end else begin
          count_nxt[i*WIDTH +: WIDTH] = cur + WIDTH'(1);
        end
      end
      if (do_dec) begin
        if (cur == '0) begin
          unf_nxt[i] = 1'b1;
          if (wrap_mode[i]) count_nxt[i*WIDTH +: WIDTH] = '1;
        end else begin
          count_nxt[i*WIDTH +: WIDTH] = cur - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      tick       <= '0;
      count      <= '0;
      eq_zero    <= '0;
      cmp_hit    <= '0;
      overflow   <= '0;
      underflow  <= '0;
      prev_match <= '0;
    end else begin
      count      <= count_nxt;
      overflow   <= ovf_nxt;
      underflow  <= unf_nxt;
      cmp_hit    <= match & ~prev_match;
      prev_match <= match;
      for (int unsigned i = 0; i < N_CH; i++) begin
        eq_zero[i] <= (count[i*WIDTH +: WIDTH] == '0);
        // Reload is sampled only when the divider expires, so a new
        // div_reload takes effect at the next period boundary.
        if (div_q[i*DIV_W +: DIV_W] == '0) begin
          div_q[i*DIV_W +: DIV_W] <= div_reload[i*DIV_W +: DIV_W];
          tick[i]                 <= 1'b1;
        end else begin
          div_q[i*DIV_W +: DIV_W] <= div_q[i*DIV_W +: DIV_W] - DIV_W'(1);
          tick[i]                 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

  logic        sys_clk;
  logic        reset;
  logic [95:0] div_reload;
  logic [3:0]  ch_enable;
  logic [3:0]  wrap_mode;
  logic [3:0]  ch_clear;
  logic [3:0]  load_pulse;
  logic [31:0] load_value;
  logic [3:0]  up_pulse;
  logic [3:0]  down_pulse;
  logic [31:0] cmp_value;
  logic [31:0] count;
  logic [3:0]  tick;
  logic [3:0]  eq_zero;
  logic [3:0]  cmp_hit;
  logic [3:0]  overflow;
  logic [3:0]  underflow;

  int nvec  = 0;
  int nfail = 0;

  counter_bank #(.N_CH(4), .WIDTH(8), .DIV_W(24)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .div_reload (div_reload),
    .ch_enable  (ch_enable),
    .wrap_mode  (wrap_mode),
    .ch_clear   (ch_clear),
    .load_pulse (load_pulse),
    .load_value (load_value),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .cmp_value  (cmp_value),
    .count      (count),
    .tick       (tick),
    .eq_zero    (eq_zero),
    .cmp_hit    (cmp_hit),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    int         ch;
    logic       clr, ld, up, dn, wrap, en;
    logic [7:0] ldv;
    logic [7:0] cnt;
    logic       ovf, unf, eqz, hit;
  } vec_t;

  vec_t vecs [32];

  function automatic vec_t mk(int ch, logic clr, logic ld, logic up, logic dn,
                              logic wrap, logic en, logic [7:0] ldv,
                              logic [7:0] cnt, logic ovf, logic unf,
                              logic eqz, logic hit);
    vec_t v;
    v.ch = ch; v.clr = clr; v.ld = ld; v.up = up; v.dn = dn;
    v.wrap = wrap; v.en = en; v.ldv = ldv; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.eqz = eqz; v.hit = hit;
    return v;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int tag,
                     input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", nm, tag, act, exp);
    end
  endtask

  // Free-running check after a reset release at posedge+1.
  // Reloads: ch0=3, ch1=1, ch2=2, ch3=0; only ch0 enabled; cmp ch0=5, ch3=0.
  task automatic run_check(input int n);
    logic [3:0] exp_tick;
    logic [7:0] exp_c0;
    for (int e = 1; e <= n; e++) begin
      step();
      exp_tick = {1'b1, ((e - 1) % 3 == 0), (e % 2 == 1), (e % 4 == 1)};
      exp_c0   = (e >= 2) ? 8'((e - 2) / 4 + 1) : 8'h00;
      chk("tick", e, 64'(tick), 64'(exp_tick));
      chk("count", e, 64'(count), {32'h0, 24'h0, exp_c0});
      chk("eqz_hit", e, 64'({eq_zero, cmp_hit}),
          64'({3'b111, (e <= 2), (e == 1), 2'b00, (e == 19)}));
      chk("ovf_unf", e, 64'({overflow, underflow}), 64'h0);
    end
  endtask

  initial begin
    // compare: ch0 5 -> 4 -> 5 re-fires
    vecs[0]  = mk(0,0,1,0,0,1,0,8'h04, 8'h04,0,0,0,0);
    vecs[1]  = mk(0,0,0,1,0,1,0,8'h00, 8'h05,0,0,0,0);
    vecs[2]  = mk(0,0,0,0,0,1,0,8'h00, 8'h05,0,0,0,1);
    vecs[3]  = mk(0,0,0,0,0,1,0,8'h00, 8'h05,0,0,0,0);
    vecs[4]  = mk(0,0,0,0,1,1,0,8'h00, 8'h04,0,0,0,0);
    vecs[5]  = mk(0,0,0,1,0,1,0,8'h00, 8'h05,0,0,0,0);
    vecs[6]  = mk(0,0,0,0,0,1,0,8'h00, 8'h05,0,0,0,1);
    vecs[7]  = mk(0,0,0,0,0,1,0,8'h00, 8'h05,0,0,0,0);
    // wrap then saturate on ch1
    vecs[8]  = mk(1,0,1,0,0,1,0,8'hFE, 8'hFE,0,0,1,0);
    vecs[9]  = mk(1,0,0,1,0,1,0,8'h00, 8'hFF,0,0,0,0);
    vecs[10] = mk(1,0,0,1,0,1,0,8'h00, 8'h00,1,0,0,0);
    vecs[11] = mk(1,0,0,1,0,1,0,8'h00, 8'h01,0,0,1,0);
    vecs[12] = mk(1,0,1,0,0,0,0,8'hFE, 8'hFE,0,0,0,0);
    vecs[13] = mk(1,0,0,1,0,0,0,8'h00, 8'hFF,0,0,0,0);
    vecs[14] = mk(1,0,0,1,0,0,0,8'h00, 8'hFF,1,0,0,0);
    vecs[15] = mk(1,0,0,1,0,0,0,8'h00, 8'hFF,1,0,0,0);
    vecs[16] = mk(1,0,0,0,0,0,0,8'h00, 8'hFF,0,0,0,0);
    // underflow on ch2
    vecs[17] = mk(2,0,0,0,1,1,0,8'h00, 8'hFF,0,1,1,0);
    vecs[18] = mk(2,0,0,0,0,1,0,8'h00, 8'hFF,0,0,0,0);
    vecs[19] = mk(2,0,1,0,0,0,0,8'h00, 8'h00,0,0,0,0);
    vecs[20] = mk(2,0,0,0,1,0,0,8'h00, 8'h00,0,1,1,0);
    vecs[21] = mk(2,0,0,0,0,0,0,8'h00, 8'h00,0,0,1,0);
    // priority on ch3 (tick every cycle, cmp 0)
    vecs[22] = mk(3,0,1,0,0,1,0,8'h55, 8'h55,0,0,1,0);
    vecs[23] = mk(3,1,1,1,0,1,0,8'h55, 8'h00,0,0,0,0);
    vecs[24] = mk(3,0,0,1,1,1,1,8'h00, 8'h00,0,0,1,1);
    vecs[25] = mk(3,0,0,1,1,1,1,8'h00, 8'h00,0,0,1,0);
    vecs[26] = mk(3,0,0,0,0,1,1,8'h00, 8'h01,0,0,1,0);
    vecs[27] = mk(3,0,0,0,0,1,0,8'h00, 8'h01,0,0,0,0);
    vecs[28] = mk(3,0,1,0,0,0,0,8'hFF, 8'hFF,0,0,0,0);
    vecs[29] = mk(3,0,0,1,1,0,0,8'h00, 8'hFF,0,0,0,0);
    vecs[30] = mk(3,0,0,0,0,1,1,8'h00, 8'h00,1,0,0,0);
    vecs[31] = mk(3,0,0,0,0,1,0,8'h00, 8'h00,0,0,1,1);

    reset      = 1'b1;
    div_reload = {24'd0, 24'd2, 24'd1, 24'd3};
    ch_enable  = 4'b0001;
    wrap_mode  = 4'hF;
    ch_clear   = '0;
    load_pulse = '0;
    load_value = '0;
    up_pulse   = '0;
    down_pulse = '0;
    cmp_value  = {8'h00, 8'h80, 8'h80, 8'h05};

    step();
    step();
    chk("reset_state", 0,
        {count, tick, eq_zero, cmp_hit, overflow, underflow}, 64'h0);
    reset = 1'b0;

    run_check(40);
    ch_enable = '0;

    for (int i = 0; i < 32; i++) begin
      ch_clear   = '0;
      load_pulse = '0;
      up_pulse   = '0;
      down_pulse = '0;
      ch_enable  = '0;
      ch_clear[vecs[i].ch]   = vecs[i].clr;
      load_pulse[vecs[i].ch] = vecs[i].ld;
      up_pulse[vecs[i].ch]   = vecs[i].up;
      down_pulse[vecs[i].ch] = vecs[i].dn;
      wrap_mode[vecs[i].ch]  = vecs[i].wrap;
      ch_enable[vecs[i].ch]  = vecs[i].en;
      load_value[vecs[i].ch*8 +: 8] = vecs[i].ldv;
      step();
      chk("vector", i,
          64'({count[vecs[i].ch*8 +: 8], overflow[vecs[i].ch],
               underflow[vecs[i].ch], eq_zero[vecs[i].ch],
               cmp_hit[vecs[i].ch]}),
          64'({vecs[i].cnt, vecs[i].ovf, vecs[i].unf, vecs[i].eqz,
               vecs[i].hit}));
    end
    ch_clear   = '0;
    load_pulse = '0;
    up_pulse   = '0;
    down_pulse = '0;
    ch_enable  = '0;
    wrap_mode  = 4'hF;

    // Mid-operation asynchronous reset.
    load_pulse[0]    = 1'b1;
    load_value[7:0]  = 8'h23;
    step();
    load_pulse = '0;
    chk("load_23", 0, 64'(count[7:0]), 64'h23);
    ch_enable = 4'b0001;
    step();
    step();
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", 1,
        {count, tick, eq_zero, cmp_hit, overflow, underflow}, 64'h0);
    step();
    reset = 1'b0;
    run_check(12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
